// File: rtl/cpu_control.sv
`default_nettype none
// ------------------------------------------------------------------
// cpu_control: multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the
// accumulator CPU, driving the ALU and consuming its results.
// Rev 1.0
// ------------------------------------------------------------------
module cpu_control #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [15:0]       instr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_neg,
  output logic [DATA_W-1:0] acc,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_MEM    = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_NEG   = 4'h5;
  localparam logic [3:0] OP_INC   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JN    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic              z;
  logic              n;
  logic [3:0]        op_d;
  logic              branch_taken;

  // Decode works on the live instruction word, not on ir.
  assign op_d         = instr[15:12];
  assign branch_taken = (op_d == OP_JMP) || ((op_d == OP_JZ) && z) || ((op_d == OP_JN) && n);
  assign mem_wdata    = acc;

  if (ADDR_W < 12) begin : g_unused_instr
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[11:ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      pc      <= '0;
      acc     <= '0;
      z       <= 1'b1;
      n       <= 1'b0;
      halted  <= 1'b0;
      ir_op   <= '0;
      ir_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        ir_op   <= op_d;
        ir_addr <= instr[ADDR_W-1:0];
        if (op_d != OP_HALT) begin
          pc <= branch_taken ? instr[ADDR_W-1:0] : pc + 1'b1;
        end
      end
      if (state == S_EXEC) begin
        acc <= alu_out;
        z   <= alu_zero;
        n   <= alu_neg;
      end
      if (state_nxt == S_HALT) begin
        halted <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op_d)
          OP_HALT:                          state_nxt = S_HALT;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_nxt = S_MEM;
          OP_NEG, OP_INC:                   state_nxt = S_EXEC;
          default:                          state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    state_nxt = (ir_op == OP_STORE) ? S_FETCH : S_EXEC;
      S_EXEC:   state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    mem_addr   = (state == S_DECODE) ? instr[ADDR_W-1:0] : ir_addr;
    mem_we     = reset_n && (state == S_MEM) && (ir_op == OP_STORE);
    alu_opcode = 3'b100;
    alu_A      = acc;
    alu_B      = acc;
    if (state == S_EXEC) begin
      case (ir_op)
        OP_LOAD: alu_A = mem_rdata;
        OP_ADD: begin
          alu_opcode = 3'b000;
          alu_A      = mem_rdata;
        end
        OP_SUB: begin
          alu_opcode = 3'b011;
          alu_A      = mem_rdata;
        end
        OP_NEG:  alu_opcode = 3'b010;
        OP_INC:  alu_opcode = 3'b001;
        default: alu_opcode = 3'b100;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cpu_control: vector table, corner sequences and random programs
// checked against an instruction-level model of the CPU.
// Rev 1.0
// ------------------------------------------------------------------
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  pc, mem_addr;
  logic [15:0] instr;
  logic [31:0] mem_rdata, mem_wdata, alu_A, alu_B, alu_out, acc;
  logic        mem_we, alu_zero, alu_neg, halted;
  logic [2:0]  alu_opcode;

  always #5 clk = ~clk;

  cpu_control #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .instr(instr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .alu_opcode(alu_opcode), .alu_A(alu_A), .alu_B(alu_B),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .acc(acc), .halted(halted)
  );

  // Synchronous-read memories and a combinational ALU around the DUT.
  logic [15:0] imem  [256];
  logic [31:0] dmem  [256];
  logic [31:0] dinit [256];
  logic [31:0] mdm   [256];
  logic        load_mem = 1'b0;

  always @(posedge clk) begin
    instr     <= imem[pc];
    mem_rdata <= dmem[mem_addr];
    if (load_mem) dmem <= dinit;
    else if (mem_we) dmem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    case (alu_opcode)
      3'b000:  alu_out = alu_A + alu_B;
      3'b001:  alu_out = alu_B + 32'd1;
      3'b010:  alu_out = -alu_A;
      3'b011:  alu_out = alu_B - alu_A;
      default: alu_out = alu_A;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_neg  = alu_out[31];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      imem[i]  = 16'hF000;
      dinit[i] = 32'd0;
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    load_mem = 1'b1;
    step();
    step();
    load_mem = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    reset_n = 1'b1;
    cyc = 0;
    while (!halted && cyc < 3000) begin
      step();
      cyc++;
    end
  endtask

  // Instruction-level model: whole instructions at a time, with a fixed cost each.
  task automatic model(output logic [31:0] macc, output logic [7:0] mpc, output int mcyc);
    logic [7:0]  p, ad, np;
    logic [31:0] a;
    logic [15:0] w;
    bit z, n, done, upd;
    p = 8'd0; a = 32'd0; z = 1'b1; n = 1'b0; mcyc = 0; done = 1'b0;
    for (int i = 0; i < 256; i++) mdm[i] = dinit[i];
    for (int k = 0; k < 1000 && !done; k++) begin
      w = imem[p]; ad = w[7:0]; np = p + 8'd1; upd = 1'b0;
      case (w[15:12])
        4'h1: begin a = mdm[ad];     mcyc += 4; upd = 1'b1; end
        4'h2: begin mdm[ad] = a;     mcyc += 3; end
        4'h3: begin a = a + mdm[ad]; mcyc += 4; upd = 1'b1; end
        4'h4: begin a = a - mdm[ad]; mcyc += 4; upd = 1'b1; end
        4'h5: begin a = -a;          mcyc += 3; upd = 1'b1; end
        4'h6: begin a = a + 32'd1;   mcyc += 3; upd = 1'b1; end
        4'h7: begin np = ad;         mcyc += 2; end
        4'h8: begin if (z) np = ad;  mcyc += 2; end
        4'h9: begin if (n) np = ad;  mcyc += 2; end
        4'hF: begin np = p; done = 1'b1; mcyc += 2; end
        default: mcyc += 2;
      endcase
      if (upd) begin z = (a == 32'd0); n = a[31]; end
      p = np;
    end
    macc = a; mpc = p;
  endtask

  typedef struct {
    string          name;
    logic [0:5][15:0] prog;
    logic [15:0]    wff;
    logic [31:0]    m5, m6;
    logic [31:0]    e_acc;
    logic [7:0]     e_pc;
    int             e_cyc;
    logic [31:0]    e_m7;
  } vec_t;

  vec_t vt[9];

  initial begin
    int cyc;
    logic [31:0] macc;
    logic [7:0]  mpc;
    int mcyc;

    vt[0] = '{name:"ld_add_st", prog:{16'h1005,16'h3006,16'h2007,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd3, m6:32'd4, e_acc:32'd7, e_pc:8'd3, e_cyc:13, e_m7:32'd7};
    vt[1] = '{name:"jn_taken", prog:{16'h1005,16'h9020,16'hF000,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'h8000_0000, m6:32'd0, e_acc:32'h8000_0000, e_pc:8'h20, e_cyc:8, e_m7:32'd0};
    vt[2] = '{name:"jn_untaken", prog:{16'h1005,16'h9020,16'hF000,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd1, m6:32'd0, e_acc:32'd1, e_pc:8'd2, e_cyc:8, e_m7:32'd0};
    vt[3] = '{name:"jz_taken", prog:{16'h6000,16'h1005,16'h8009,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd0, m6:32'd0, e_acc:32'd0, e_pc:8'd9, e_cyc:11, e_m7:32'd0};
    vt[4] = '{name:"inc_neg", prog:{16'h1005,16'h6000,16'h8009,16'h5000,16'h9020,16'hF000}, wff:16'hF000,
              m5:32'd0, m6:32'd0, e_acc:32'hFFFF_FFFF, e_pc:8'h20, e_cyc:16, e_m7:32'd0};
    vt[5] = '{name:"sub_neg", prog:{16'h1005,16'h4006,16'h2007,16'h9020,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd2, m6:32'd5, e_acc:32'hFFFF_FFFD, e_pc:8'h20, e_cyc:15, e_m7:32'hFFFF_FFFD};
    vt[6] = '{name:"sub_zero", prog:{16'h1005,16'h4006,16'h8009,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd5, m6:32'd5, e_acc:32'd0, e_pc:8'd9, e_cyc:12, e_m7:32'd0};
    vt[7] = '{name:"op_b_nop", prog:{16'hB000,16'h0000,16'h6000,16'hF000,16'hF000,16'hF000}, wff:16'hF000,
              m5:32'd0, m6:32'd0, e_acc:32'd1, e_pc:8'd3, e_cyc:9, e_m7:32'd0};
    vt[8] = '{name:"pc_wrap", prog:{16'h8002,16'hF000,16'h6000,16'h70FF,16'hF000,16'hF000}, wff:16'h0000,
              m5:32'd0, m6:32'd0, e_acc:32'd1, e_pc:8'd1, e_cyc:13, e_m7:32'd0};

    // Reset state
    clear_mems();
    do_reset();
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_acc", acc, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_alu_op", {29'd0, alu_opcode}, 32'd4);
    check("rst_alu_A", alu_A, 32'd0);
    check("rst_alu_B", alu_B, 32'd0);

    // Vector table
    for (int v = 0; v < 9; v++) begin
      clear_mems();
      for (int i = 0; i < 6; i++) imem[i] = vt[v].prog[i];
      imem[255] = vt[v].wff;
      dinit[5] = vt[v].m5;
      dinit[6] = vt[v].m6;
      do_reset();
      run_to_halt(cyc);
      check({vt[v].name, "_cyc"}, 32'(cyc), 32'(vt[v].e_cyc));
      check({vt[v].name, "_acc"}, acc, vt[v].e_acc);
      check({vt[v].name, "_pc"}, {24'd0, pc}, {24'd0, vt[v].e_pc});
      check({vt[v].name, "_m7"}, dmem[7], vt[v].e_m7);
      step(); step(); step();
      check({vt[v].name, "_pc_hold"}, {24'd0, pc}, {24'd0, vt[v].e_pc});
      check({vt[v].name, "_halt_hold"}, {31'd0, halted}, 32'd1);
    end

    // LOAD drives the ALU, then JN redirects pc two cycles after its fetch
    clear_mems();
    imem[0] = 16'h1005; imem[1] = 16'h9020;
    dinit[5] = 32'h8000_0000;
    do_reset();
    reset_n = 1'b1;
    step(); step(); step();
    check("exec_alu_op", {29'd0, alu_opcode}, 32'd4);
    check("exec_alu_A", alu_A, 32'h8000_0000);
    step(); step();
    check("jn_decode_pc", {24'd0, pc}, 32'd1);
    check("jn_decode_addr", {24'd0, mem_addr}, 32'h20);
    step();
    check("jn_target_pc", {24'd0, pc}, 32'h20);

    // Reset in the MEM cycle of a STORE suppresses the write
    clear_mems();
    imem[0] = 16'h1005; imem[1] = 16'h2007;
    dinit[5] = 32'd9;
    do_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("store_mem_we", {31'd0, mem_we}, 32'd1);
    check("store_mem_addr", {24'd0, mem_addr}, 32'd7);
    reset_n = 1'b0;
    #1;
    check("store_rst_we", {31'd0, mem_we}, 32'd0);
    step();
    check("store_rst_pc", {24'd0, pc}, 32'd0);
    check("store_rst_acc", acc, 32'd0);
    check("store_rst_m7", dmem[7], 32'd0);
    run_to_halt(cyc);
    check("store_rerun_cyc", 32'(cyc), 32'd9);
    check("store_rerun_m7", dmem[7], 32'd9);

    // Reset while halted restarts execution at 0
    reset_n = 1'b0;
    step();
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    check("halt_rst_pc", {24'd0, pc}, 32'd0);
    run_to_halt(cyc);
    check("halt_rerun_cyc", 32'(cyc), 32'd9);
    check("halt_rerun_pc", {24'd0, pc}, 32'd2);

    // Random forward-branching programs against the instruction-level model
    for (int t = 0; t < 30; t++) begin
      int len;
      int mism;
      logic [3:0] op;
      logic [7:0] ad;
      clear_mems();
      len = $urandom_range(4, 24);
      for (int i = 0; i < len - 1; i++) begin
        op = 4'($urandom_range(0, 14));
        if (op >= 4'h1 && op <= 4'h4) ad = 8'($urandom_range(0, 15));
        else if (op >= 4'h7 && op <= 4'h9) ad = 8'($urandom_range(i + 1, len - 1));
        else ad = 8'($urandom_range(0, 255));
        imem[i] = {op, 4'($urandom_range(0, 15)), ad};
      end
      imem[len - 1] = {4'hF, 12'($urandom_range(0, 4095))};
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 5))
          0: dinit[i] = 32'd0;
          1: dinit[i] = 32'd1;
          2: dinit[i] = 32'h8000_0000;
          3: dinit[i] = 32'h7FFF_FFFF;
          4: dinit[i] = 32'hFFFF_FFFF;
          default: dinit[i] = $urandom;
        endcase
      end
      model(macc, mpc, mcyc);
      do_reset();
      run_to_halt(cyc);
      mism = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== mdm[i]) mism++;
      check("rand_cyc", 32'(cyc), 32'(mcyc));
      check("rand_acc", acc, macc);
      check("rand_pc", {24'd0, pc}, {24'd0, mpc});
      check("rand_dmem_mismatches", 32'(mism), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
